// File: rtl/adder_ctrl_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder sequencer.
package adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NIBBLE_W = 4;

  function automatic int unsigned nib_steps(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/adder_4bits.sv
// Combinational 4-bit ripple-carry adder slice.
module adder_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic c;

  always_comb begin
    s = '0;
    c = cin;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds two WIDTH-bit operands one nibble per cycle through a single 4-bit slice,
// with valid/ready handshakes on operand and result sides.
module nibble_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             V,
  output logic             busy
);

  localparam int unsigned NIB    = nib_steps(WIDTH);
  localparam int unsigned STEP_W = $clog2(NIB);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NIB - 1);

  state_t state_q;
  state_t state_d;

  logic [NIB-1:0][NIBBLE_W-1:0] a_q;
  logic [NIB-1:0][NIBBLE_W-1:0] b_q;
  logic [NIB-1:0][NIBBLE_W-1:0] sum_q;
  logic                         carry_q;
  logic [STEP_W-1:0]            step_q;
  logic [NIBBLE_W-1:0]          slice_s;
  logic                         slice_cout;

  adder_4bits u_slice (
    .a    (a_q[step_q]),
    .b    (b_q[step_q]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  assign SUM = sum_q;

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (step_q == LAST_STEP) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      step_q    <= '0;
      COUT      <= 1'b0;
      V         <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= Cin;
            sum_q   <= '0;
            step_q  <= '0;
          end
        end
        RUN: begin
          sum_q[step_q] <= slice_s;
          carry_q       <= slice_cout;
          step_q        <= step_q + STEP_W'(1);
          // Overflow uses the MSB of the final nibble as it is written
          if (step_q == LAST_STEP) begin
            COUT <= slice_cout;
            V    <= (a_q[NIB-1][NIBBLE_W-1] == b_q[NIB-1][NIBBLE_W-1]) &&
                    (slice_s[NIBBLE_W-1] != a_q[NIB-1][NIBBLE_W-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed self-checking bench for nibble_serial_adder_ctrl at WIDTH=16.
module tb_nibble_serial_adder_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        v;
  logic        busy;

  int total = 0;
  int bad   = 0;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_i),
    .B         (b_i),
    .Cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .SUM       (sum),
    .COUT      (cout),
    .V         (v),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand set, wait for the result, check it, then hand it off.
  task automatic run_add(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic [15:0] es, input logic ec, input logic ev);
    int n;
    check("pre_in_ready", 32'(in_ready), 32'd1);
    a_i = a; b_i = b; cin = c; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; a_i = 16'h5A5A; b_i = 16'hC3C3; cin = ~c;
    n = 0;
    while (!out_valid && n < 20) begin
      if (in_ready) begin
        bad++; total++;
        $display("FAIL in_ready_run: got=1 expected=0 at step %0d", n);
      end
      tick();
      n++;
    end
    check("latency", 32'(n), 32'd4);
    check("done_in_ready", 32'(in_ready), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    check("sum", 32'(sum), 32'(es));
    check("cout", 32'(cout), 32'(ec));
    check("v", 32'(v), 32'(ev));
    tick();
    check("handoff_out_valid", 32'(out_valid), 32'd0);
    check("handoff_in_ready", 32'(in_ready), 32'd1);
    check("handoff_sum_kept", 32'(sum), 32'(es));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_i = '0; b_i = '0; cin = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'h0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    check("rel_in_ready", 32'(in_ready), 32'd1);

    run_add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_add(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_add(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_add(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Backpressure: result must hold while the consumer stalls
    out_ready = 1'b0;
    a_i = 16'h1111; b_i = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_sum", 32'(sum), 32'h3333);
    for (int i = 0; i < 5; i++) begin
      a_i = 16'hAAAA; b_i = 16'hAAAA; in_valid = (i % 2 == 0);
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_sum", 32'(sum), 32'h3333);
      check("bp_hold_cv", 32'({cout, v}), 32'd0);
      check("bp_no_accept", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_sum", 32'(sum), 32'h3333);

    // Reset mid-operation discards the partial result
    a_i = 16'h1234; b_i = 16'h4321; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("abort_partial_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    run_add(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
